receptor_uart: RTL
==================

Name: receptor_uart

Overview:
Serial UART receiver: 8 data bits, LSB first, one parity bit, one stop bit.
Sits directly upstream of the configuration decoder and produces the three signals that decoder consumes: received character dato, completion strobe hecho, and error flag ERRrx.
The decoder latches on the rising edge of hecho, so dato and ERRrx must be stable one clock before hecho rises.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
PARIDAD_IMPAR, 0, selects parity: 0 = even, 1 = odd.
CICLOS_BIT (localparam), CLK_HZ/BAUD (integer division), clocks per bit; must be >= 8.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
rx  input  1  serial line; idles high; asynchronous to clk.
dato  output  8  last received character.
hecho  output  1  one-clock strobe marking a completed frame.
ERRrx  output  1  error flag for the character in dato: parity or framing error.
ocupado  output  1  high while a frame is being received.

Behaviour:
- Reset (async, rst=1): dato=8'h00, hecho=0, ERRrx=0, ocupado=0, state REPOSO, counters 0, synchronizer flops set to 1 (idle).
- Reset asserted mid-frame abandons the frame. No hecho is produced for it.
- Input path: rx passes through a 2-flop synchronizer (rx_s), then one more register for edge detect. Every sampling decision uses rx_s.
- States: REPOSO, INICIO, DATOS, PARIDAD, PARADA, ENTREGA, ESPERA_ALTO.
- REPOSO:
  - a falling edge on rx_s (prev=1, now=0) -> INICIO, counter cleared, ocupado=1.
- INICIO:
  - count to CICLOS_BIT/2 - 1, then sample rx_s (mid start bit).
  - sample 1 = false start -> REPOSO, ocupado=0, no outputs change.
  - sample 0 -> DATOS, counter cleared, bit index 0.
- DATOS:
  - every CICLOS_BIT clocks, sample rx_s into shift register bit [index], LSB first.
  - after index 7 is sampled -> PARIDAD.
- PARIDAD:
  - sample after CICLOS_BIT clocks.
  - err_par = (^data ^ sample) != PARIDAD_IMPAR.
  - even parity expects the XOR of data and parity bit to be 0.
  - -> PARADA.
- PARADA:
  - sample after CICLOS_BIT clocks; err_trama = (sample == 0).
  - On that sampling clock edge: dato <= shift register, ERRrx <= err_par | err_trama. Both registered in the same cycle.
  - -> ENTREGA.
- ENTREGA: hecho=1 for exactly this one clock, then hecho returns to 0.
  - err_trama=0 -> REPOSO, ocupado=0.
  - err_trama=1 -> ESPERA_ALTO.
- ESPERA_ALTO: stays until rx_s==1, then -> REPOSO, ocupado=0. A break or stuck-low line produces only one hecho.
- Latency: hecho rises exactly 1 clock after dato/ERRrx update. From the rx stop-bit midpoint to hecho high: 2 synchronizer clocks + 1 + 1.
- dato and ERRrx hold their values until the next completed frame.
- A frame with an error still updates dato and still pulses hecho. The decoder relies on this to advance its position counter.
- A falling edge during PARADA or ENTREGA is ignored. A new start is detected only in REPOSO, so back-to-back frames with exactly one stop bit must still be received. The PARADA sample is at mid-stop-bit, leaving half a bit for ENTREGA before the next start edge.
- Counters are sized to hold CICLOS_BIT-1. The bit index is 3 bits and never wraps past 7.

Test Plan (CLK_HZ=160, BAUD=10 -> CICLOS_BIT=16, PARIDAD_IMPAR=0):
1. Send 0x35 with parity 0 and stop 1 -> dato=8'h35, ERRrx=0, exactly one hecho pulse one clock wide; dato stable the clock before hecho rises; ocupado low afterwards.
2. Send 0x35 with parity bit 1 -> dato=8'h35, ERRrx=1, one hecho pulse. Then a clean 0x31 -> ERRrx=0.
3. Send 0x42 with stop bit 0, hold rx low for 40 more clocks, then release high -> one hecho with ERRrx=1, no second hecho, ocupado drops only after rx high.
4. Drive rx low for 5 clocks (less than half a bit), then high -> no hecho, dato unchanged, state returns to REPOSO.
5. Send 16 consecutive frames "1","2",...,"9","0",... with one stop bit each and no idle gap -> 16 hecho pulses, each dato matches the sent character, ERRrx=0 throughout.
6. Assert rst in the middle of DATOS while receiving 0x55 -> outputs immediately 0, no hecho. After release, a clean 0x37 is received correctly.

Source files
------------

// File: rtl/receptor_uart.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Outputs the character, an error flag and a completion strobe one clock later.
module receptor_uart #(
  parameter int CLK_HZ        = 50000000,
  parameter int BAUD          = 9600,
  parameter int PARIDAD_IMPAR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dato,
  output logic       hecho,
  output logic       ERRrx,
  output logic       ocupado
);

  localparam int CICLOS_BIT = CLK_HZ / BAUD;
  localparam int CW = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
  localparam logic [CW-1:0] ULT   = CW'(CICLOS_BIT - 1);
  localparam logic [CW-1:0] MEDIO = CW'(CICLOS_BIT / 2 - 1);
  localparam logic IMPAR = (PARIDAD_IMPAR != 0);

  typedef enum logic [2:0] {
    REPOSO,
    INICIO,
    DATOS,
    PARIDAD,
    PARADA,
    ENTREGA,
    ESPERA_ALTO
  } estado_t;

  estado_t       estado;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          err_par;
  logic          err_trama;
  logic          rx_m;
  logic          rx_s;
  logic          rx_p;
  logic          bajada;

  assign bajada = rx_p & ~rx_s;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  // Frame FSM: mid-bit sampling, result registration and strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= REPOSO;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      err_par   <= 1'b0;
      err_trama <= 1'b0;
      dato      <= 8'h00;
      hecho     <= 1'b0;
      ERRrx     <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      hecho <= 1'b0;
      case (estado)
        REPOSO: begin
          if (bajada) begin
            estado  <= INICIO;
            cnt     <= '0;
            ocupado <= 1'b1;
          end
        end
        INICIO: begin
          if (cnt == MEDIO) begin
            cnt <= '0;
            if (rx_s) begin
              estado  <= REPOSO;
              ocupado <= 1'b0;
            end else begin
              estado <= DATOS;
              idx    <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATOS: begin
          if (cnt == ULT) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
              estado <= PARIDAD;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARIDAD: begin
          if (cnt == ULT) begin
            cnt     <= '0;
            err_par <= ((^shreg) ^ rx_s) != IMPAR;
            estado  <= PARADA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARADA: begin
          if (cnt == ULT) begin
            cnt       <= '0;
            err_trama <= ~rx_s;
            dato      <= shreg;
            ERRrx     <= err_par | ~rx_s;
            estado    <= ENTREGA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ENTREGA: begin
          hecho <= 1'b1;
          if (err_trama) begin
            estado <= ESPERA_ALTO;
          end else begin
            estado  <= REPOSO;
            ocupado <= 1'b0;
          end
        end
        ESPERA_ALTO: begin
          if (rx_s) begin
            estado  <= REPOSO;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= REPOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
